regfile_dump: RTL



---
 rtl/regfile_dump.sv | 106 ++++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// regfile_dump
//   Walks register-file indices 0..NREGS-1 through one read port. Each value
//   is captured and offered on a valid/ready stream. A running XOR checksum
//   of the accepted values is kept, and done pulses after the last beat.
//
// Ports
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset
//   start      begin a dump (only looked at in IDLE)
//   abort      cancel an in-progress dump, no done pulse
//   rd_addr    register-file read address (registered)
//   rd_data    combinational register-file read data for rd_addr
//   out_valid  out_idx/out_data valid
//   out_ready  consumer accept
//   out_idx    index of presented register
//   out_data   captured register value
//   busy       high in READ, SEND, DONE
//   done       one-cycle pulse after the last register is accepted
//   checksum   XOR of accepted values of the current/most recent dump
module regfile_dump #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t        state;
    logic [AW-1:0] idx;

    // The index register doubles as the read address: it only moves on a
    // SEND handshake, so it is already stable for the whole READ cycle.
    assign rd_addr = idx;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            out_idx   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // start beats abort here; abort alone is a no-op
                    if (start) begin
                        idx      <= '0;
                        checksum <= '0;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        out_data  <= rd_data;
                        out_idx   <= idx;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // abort wins over a simultaneous handshake; that beat
                    // never reaches the checksum
                    if (abort) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        checksum  <= checksum ^ out_data;
                        out_valid <= 1'b0;
                        if (idx == LAST) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + AW'(1);
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
